// File: rtl/svi_rr_pkg.sv
// Shared types and helpers for the SVI round-robin responder.
// Holds the FSM state type and the index-width helper.
package svi_rr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    ACK   = 2'd2
  } rr_state_t;

  function automatic int IDX_W(input int size);
    return $clog2(size);
  endfunction

endpackage

// File: rtl/svi_i.sv
// Single-lane SVI link: y carries a request, x carries a one-cycle acknowledge.
// P is the initiator end, Q the responder end.
interface I;
  logic x;
  logic y;

  modport P (input x, output y);
  modport Q (output x, input y);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping from SIZE-1 back to 0.
module rr_pick
  import svi_rr_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0]          req_i,
  input  logic [IDX_W(SIZE)-1:0]   ptr_i,
  output logic                     any_o,
  output logic [IDX_W(SIZE)-1:0]   idx_o
);

  localparam int IW = IDX_W(SIZE);

  always_comb begin
    int cand;
    logic [IW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    any_o    = |req_i;
    idx_o    = '0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int i = SIZE - 1; i >= 0; i--) begin
      cand = int'(ptr_i) + i;
      if (cand >= SIZE) cand = cand - SIZE;
      cand_idx = IW'(cand);
      if (req_i[cand_idx]) idx_o = cand_idx;
    end
  end

endmodule

// File: rtl/svi_rr_responder.sv
// Responder for an SVI array: round-robin arbitration of lane requests,
// valid/ready offer of the winner, then a one-cycle acknowledge on its lane.
module svi_rr_responder
  import svi_rr_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  I.Q                            p [SIZE-1:0],
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [IDX_W(SIZE)-1:0] o_idx,
  output logic [CNT_W-1:0]       o_cnt,
  output logic                   o_busy
);

  localparam int IW = IDX_W(SIZE);

  rr_state_t        state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0]  x_q, x_d;
  logic [SIZE-1:0]  req;
  logic             pick_any;
  logic [IW-1:0]    pick_idx;

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
    assign req[gi]  = p[gi].y;
    assign p[gi].x  = x_q[gi];
  end

  rr_pick #(.SIZE(SIZE)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    x_d     = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          idx_d   = pick_idx;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (i_ready) begin
          valid_d     = 1'b0;
          x_d[idx_q]  = 1'b1;
          state_d     = ACK;
        end
      end
      ACK: begin
        ptr_d = (idx_q == IW'(SIZE - 1)) ? '0 : idx_q + 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

  assign o_valid = valid_q;
  assign o_idx   = idx_q;
  assign o_cnt   = cnt_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_svi_rr_responder.sv
// Bench for svi_rr_responder: directed vector table, hand-written corner
// sequences, and random traffic against a transaction-level reference model.
module tb_svi_rr_responder;

  localparam int SIZE = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready;
  logic [7:0] y;

  logic       va, vb, ba, bb;
  logic [2:0] ia, ib;
  logic [15:0] ca;
  logic [1:0] cb;
  logic [7:0] xa, xb;

  int total = 0;
  int bad   = 0;

  I ifa [SIZE-1:0] ();
  I ifb [SIZE-1:0] ();

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_tb_lane
    assign ifa[gi].y = y[gi];
    assign ifb[gi].y = y[gi];
    assign xa[gi]    = ifa[gi].x;
    assign xb[gi]    = ifb[gi].x;
  end

  svi_rr_responder #(.SIZE(SIZE), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .p(ifa), .i_ready(ready),
    .o_valid(va), .o_idx(ia), .o_cnt(ca), .o_busy(ba)
  );

  svi_rr_responder #(.SIZE(SIZE), .CNT_W(2)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .p(ifb), .i_ready(ready),
    .o_valid(vb), .o_idx(ib), .o_cnt(cb), .o_busy(bb)
  );

  always #5 clk = ~clk;

  // Reference model: an offer in flight, a pending acknowledge, a pointer, a count.
  bit m_offer;
  int m_idx, m_ack, m_ptr, m_cnt;

  task automatic m_step();
    bit found;
    if (!rst_n) begin
      m_offer = 0; m_idx = 0; m_ack = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_ack >= 0) begin
      m_ptr = (m_ack + 1) % SIZE;
      m_cnt = m_cnt + 1;
      m_ack = -1;
    end else if (m_offer) begin
      if (ready) begin
        m_ack   = m_idx;
        m_offer = 0;
      end
    end else begin
      found = 0;
      for (int i = 0; i < SIZE; i++) begin
        int l;
        l = (m_ptr + i) % SIZE;
        if (!found && y[l]) begin
          found   = 1;
          m_offer = 1;
          m_idx   = l;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic [7:0] ex;
    int sat;
    ex  = (m_ack >= 0) ? (8'd1 << m_ack) : 8'd0;
    sat = (m_cnt > 3) ? 3 : m_cnt;
    chk({tag, " valid"}, 32'(va), 32'(m_offer));
    chk({tag, " idx"},   32'(ia), 32'(m_idx));
    chk({tag, " x"},     32'(xa), 32'(ex));
    chk({tag, " cnt"},   32'(ca), 32'(m_cnt));
    chk({tag, " busy"},  32'(ba), 32'(m_offer || m_ack >= 0));
    chk({tag, " s_valid"}, 32'(vb), 32'(m_offer));
    chk({tag, " s_x"},     32'(xb), 32'(ex));
    chk({tag, " s_cnt"},   32'(cb), 32'(sat));
    chk({tag, " onehot"},  32'($countones(xa) <= 1), 32'd1);
  endtask

  typedef struct {
    logic       rst_n;
    logic [7:0] y;
    logic       ready;
    logic       v;
    logic [2:0] idx;
    logic [7:0] x;
    logic [15:0] cnt;
    logic       busy;
  } vec_t;

  vec_t tbl [12];
  int   grants [$];
  int   pulses;

  initial begin
    tbl[0]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 16'd0, 1'b0};
    tbl[1]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 16'd0, 1'b0};
    tbl[2]  = '{1'b1, 8'h08, 1'b1, 1'b1, 3'd3, 8'h00, 16'd0, 1'b1};
    tbl[3]  = '{1'b1, 8'h08, 1'b1, 1'b0, 3'd3, 8'h08, 16'd0, 1'b1};
    tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00, 16'd1, 1'b0};
    tbl[5]  = '{1'b1, 8'h20, 1'b0, 1'b1, 3'd5, 8'h00, 16'd1, 1'b1};
    tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd5, 8'h00, 16'd1, 1'b1};
    tbl[7]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd5, 8'h20, 16'd1, 1'b1};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd5, 8'h00, 16'd2, 1'b0};
    tbl[9]  = '{1'b1, 8'h01, 1'b0, 1'b1, 3'd0, 8'h00, 16'd2, 1'b1};
    tbl[10] = '{1'b0, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 16'd0, 1'b0};
    tbl[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 16'd0, 1'b0};

    rst_n = 1'b0; y = 8'h00; ready = 1'b0;
    m_offer = 0; m_idx = 0; m_ack = -1; m_ptr = 0; m_cnt = 0;

    for (int i = 0; i < 12; i++) begin
      rst_n = tbl[i].rst_n; y = tbl[i].y; ready = tbl[i].ready;
      tick();
      $display("vec %0d: valid=%0b idx=%0d x=%02h cnt=%0d busy=%0b", i, va, ia, xa, ca, ba);
      chk($sformatf("vec%0d valid", i), 32'(va), 32'(tbl[i].v));
      chk($sformatf("vec%0d idx", i),   32'(ia), 32'(tbl[i].idx));
      chk($sformatf("vec%0d x", i),     32'(xa), 32'(tbl[i].x));
      chk($sformatf("vec%0d cnt", i),   32'(ca), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d busy", i),  32'(ba), 32'(tbl[i].busy));
      chk($sformatf("vec%0d s_x", i),   32'(xb), 32'(tbl[i].x));
    end

    // Round-robin over lanes 0, 2, 7 with requests held.
    rst_n = 1'b0; tick();
    rst_n = 1'b1; y = 8'b1000_0101; ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      tick();
      check_model("rr");
      for (int k = 0; k < SIZE; k++) if (xa[k]) grants.push_back(k);
    end
    chk("rr grant_count", 32'(grants.size()), 32'd6);
    for (int g = 0; g < 6 && g < grants.size(); g++) begin
      int want;
      want = (g % 3 == 0) ? 0 : ((g % 3 == 1) ? 2 : 7);
      $display("rr grant %0d: lane %0d", g, grants[g]);
      chk($sformatf("rr order%0d", g), 32'(grants[g]), 32'(want));
    end
    chk("rr cnt", 32'(ca), 32'd6);
    chk("sat cnt", 32'(cb), 32'd3);

    // Backpressure on lane 5, request dropped mid-offer.
    rst_n = 1'b0; y = 8'h00; ready = 1'b0; tick();
    rst_n = 1'b1; y = 8'h20; tick();
    chk("bp first_valid", 32'(va), 32'd1);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) y = 8'h00;
      tick();
      chk($sformatf("bp%0d valid", c), 32'(va), 32'd1);
      chk($sformatf("bp%0d idx", c),   32'(ia), 32'd5);
      chk($sformatf("bp%0d x", c),     32'(xa), 32'd0);
    end
    ready = 1'b1; tick();
    chk("bp ack_x", 32'(xa), 32'h20);
    chk("bp ack_valid", 32'(va), 32'd0);
    if (xa[5]) pulses++;
    ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (xa[5]) pulses++;
    end
    chk("bp pulses", 32'(pulses), 32'd1);
    chk("bp cnt", 32'(ca), 32'd1);
    $display("backpressure: lane 5 acknowledged, cnt=%0d", ca);

    // Random traffic against the model, with occasional resets.
    rst_n = 1'b0; tick();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      y     = 8'($urandom);
      ready = 1'($urandom_range(0, 1));
      tick();
      check_model($sformatf("rnd%0d", c));
      if (m_ack >= 0) $display("rnd %0d: grant lane %0d cnt %0d", c, m_ack, m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
